// File: rtl/posit_encoder_pipe.sv
// Posit field encoder: packs sign/scale/fraction into an N-bit posit.
// Two register stages, round-to-nearest-even, saturating at maxpos/minpos.
module posit_encoder_pipe #(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int SW = $clog2(N) + ES + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic                 in_zero,
    input  logic                 in_nar,
    input  logic signed [SW-1:0] in_scale,
    input  logic [N-1:0]         in_frac,
    input  logic                 in_sticky,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_posit
);

    localparam int BW = 2*N + ES + 2;
    localparam logic signed [SW-1:0] MAX_SCALE = SW'((N-2) * (2**ES));
    localparam logic signed [SW-1:0] MIN_SCALE = -MAX_SCALE;
    localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};

    logic adv1, adv2;
    logic s1_valid, s2_valid;

    logic          s1_sign, s1_zero, s1_nar, s1_ovf, s1_unf;
    logic [N-2:0]  s1_body;
    logic          s1_g, s1_s;

    logic signed [SW-1:0] k;
    logic [SW-1:0]        shamt;
    logic [BW-1:0]        body0;
    logic signed [BW-1:0] shifted;

    logic          inc;
    logic [N-1:0]  rounded;
    logic [N-1:0]  mag;
    logic [N-1:0]  result;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = rst_n && adv1;
    assign out_valid = s2_valid;

    // A leading "10" (k>=0) or "01" (k<0) arithmetic-shifted right yields the
    // regime run and its terminator in one step; the zero pad keeps every
    // in-range shift lossless so guard/sticky see all discarded bits.
    always_comb begin
        k       = in_scale >>> ES;
        shamt   = k[SW-1] ? ~k : k;
        body0   = {k[SW-1] ? 2'b01 : 2'b10, in_scale[ES-1:0], in_frac, {N{1'b0}}};
        shifted = $signed(body0) >>> shamt;
    end

    always_comb begin
        inc     = s1_g && (s1_s || s1_body[0]);
        rounded = {1'b0, s1_body} + {{(N-1){1'b0}}, inc};
        if (s1_ovf || rounded[N-1])
            mag = MAXPOS;
        else if (s1_unf || (rounded == '0))
            mag = MINPOS;
        else
            mag = rounded;

        if (s1_nar)
            result = NAR;
        else if (s1_zero)
            result = '0;
        else if (s1_sign)
            result = -mag;
        else
            result = mag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_posit <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign <= in_sign;
                    s1_zero <= in_zero;
                    s1_nar  <= in_nar;
                    s1_ovf  <= in_scale > MAX_SCALE;
                    s1_unf  <= in_scale < MIN_SCALE;
                    s1_body <= shifted[BW-1 -: N-1];
                    s1_g    <= shifted[BW-N];
                    s1_s    <= (|shifted[BW-N-1:0]) || in_sticky;
                end
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid)
                    out_posit <= result;
            end
        end
    end

endmodule

// File: tb/tb_posit_encoder_pipe.sv
// Self-checking bench for posit_encoder_pipe: bit-string posit model,
// directed literal vectors, randomized streaming with stalls, mid-flight reset.
module tb_posit_encoder_pipe;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic              in_zero;
    logic              in_nar;
    logic signed [8:0] in_scale;
    logic [31:0]       in_frac;
    logic              in_sticky;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_posit;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    bit          hold_pending = 0;
    logic [31:0] held_posit;

    posit_encoder_pipe #(.N(32), .ES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .in_scale  (in_scale),
        .in_frac   (in_frac),
        .in_sticky (in_sticky),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Writes out the posit as a bit string (regime run, exponent, fraction),
    // then keeps the first 31 bits and rounds on what was cut off.
    function automatic logic [31:0] model(input bit sign, input bit zero, input bit nar,
                                          input int scale, input logic [31:0] frac,
                                          input bit sticky);
        bit          bits[$];
        int          k, e;
        longint      mag;
        bit          g, s;
        logic [31:0] r;
        if (nar) return 32'h8000_0000;
        if (zero) return 32'h0;
        if (scale > 120) begin
            mag = 64'h7FFF_FFFF;
        end else if (scale < -120) begin
            mag = 64'h1;
        end else begin
            e = ((scale % 4) + 4) % 4;
            k = (scale - e) / 4;
            if (k >= 0) begin
                repeat (k + 1) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                repeat (-k) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            bits.push_back(e[1]);
            bits.push_back(e[0]);
            for (int i = 31; i >= 0; i--) bits.push_back(frac[i]);
            mag = 0;
            for (int i = 0; i < 31; i++) mag = (mag << 1) | longint'(bits[i]);
            g = bits[31];
            s = sticky;
            for (int i = 32; i < bits.size(); i++) s = s | bits[i];
            if (g && (s || mag[0])) mag = mag + 1;
            if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
            if (mag == 0) mag = 1;
        end
        r = mag[31:0];
        return sign ? -r : r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %08h expected %08h", name, got, want);
    endtask

    // Scoreboard: expectations enter at accept, leave at emit; also checks
    // back-pressure, output hold while stalled, and absence of phantom outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_pending = 0;
        end else begin
            checkOutput("in_ready_rule", 32'(in_ready),
                        (exp_q.size() == 2 && !out_ready) ? 32'd0 : 32'd1);
            checkOutput("no_phantom", 32'(out_valid && exp_q.size() == 0), 32'd0);
            if (hold_pending) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_posit", out_posit, held_posit);
            end
            if (out_valid && out_ready && exp_q.size() > 0)
                checkOutput("stream", out_posit, exp_q.pop_front());
            hold_pending = out_valid && !out_ready;
            held_posit   = out_posit;
            if (in_valid && in_ready)
                exp_q.push_back(model(in_sign, in_zero, in_nar, int'(in_scale), in_frac, in_sticky));
        end
    end

    task automatic applyStimulus(input bit sign, input bit zero, input bit nar,
                                 input int scale, input logic [31:0] frac, input bit sticky);
        bit accepted = 0;
        @(posedge clk); #2;
        in_valid  = 1'b1;
        in_sign   = sign;
        in_zero   = zero;
        in_nar    = nar;
        in_scale  = 9'(scale);
        in_frac   = frac;
        in_sticky = sticky;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) accepted = 1;
            else begin @(posedge clk); #2; end
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic runDirected(input string name, input bit sign, input bit zero, input bit nar,
                               input int scale, input logic [31:0] frac, input bit sticky,
                               input logic [31:0] want);
        bit seen = 0;
        checkOutput({name, "_model"}, model(sign, zero, nar, scale, frac, sticky), want);
        applyStimulus(sign, zero, nar, scale, frac, sticky);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                checkOutput(name, out_posit, want);
            end
        end
        if (!seen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        bit stall;
        rst_n = 1'b0;
        in_valid = 1'b0; in_sign = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
        in_scale = '0; in_frac = '0; in_sticky = 1'b0; out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_posit", out_posit, 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);

        runDirected("one",        0, 0, 0,    0, 32'h0,  0, 32'h4000_0000);
        runDirected("scale_p1",   0, 0, 0,    1, 32'h0,  0, 32'h4800_0000);
        runDirected("scale_m1",   0, 0, 0,   -1, 32'h0,  0, 32'h3800_0000);
        runDirected("neg_one",    1, 0, 0,    0, 32'h0,  0, 32'hC000_0000);
        runDirected("tie_even",   0, 0, 0,    0, 32'h10, 0, 32'h4000_0000);
        runDirected("tie_sticky", 0, 0, 0,    0, 32'h10, 1, 32'h4000_0001);
        runDirected("ovf",        0, 0, 0,  200, 32'h0,  0, 32'h7FFF_FFFF);
        runDirected("unf",        0, 0, 0, -200, 32'h0,  0, 32'h0000_0001);
        runDirected("unf_neg",    1, 0, 0, -200, 32'h0,  0, 32'hFFFF_FFFF);
        runDirected("nar_zero",   0, 1, 1,    5, 32'h0,  0, 32'h8000_0000);
        runDirected("zero_neg",   1, 1, 0,    5, 32'h0,  0, 32'h0000_0000);
        runDirected("max_scale",  0, 0, 0,  120, 32'h0,  0, 32'h7FFF_FFFF);
        runDirected("min_scale",  0, 0, 0, -120, 32'h0,  0, 32'h0000_0001);
        runDirected("near_min",   0, 0, 0, -117, 32'h0,  0, 32'h0000_0002);
        runDirected("tie_top",    0, 0, 0,  118, 32'h0,  0, 32'h7FFF_FFFE);
        runDirected("sticky_top", 0, 0, 0,  118, 32'h0,  1, 32'h7FFF_FFFF);
        runDirected("carry_up",   0, 0, 0,    0, 32'hFFFF_FFFF, 0, 32'h4800_0000);

        for (int n = 0; n < 8200; n++) begin
            @(negedge clk);
            stall = in_valid && !in_ready;
            @(posedge clk); #2;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!stall) begin
                in_valid  = ($urandom_range(0, 6) != 0);
                in_sign   = 1'($urandom_range(0, 1));
                in_zero   = ($urandom_range(0, 15) == 0);
                in_nar    = ($urandom_range(0, 31) == 0);
                in_scale  = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511))
                                                        : 9'($urandom_range(0, 260) - 130);
                in_frac   = $urandom();
                if ($urandom_range(0, 3) == 0) in_frac = in_frac & 32'hFFFF_FF00;
                in_sticky = ($urandom_range(0, 3) == 0);
            end
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("drain", 32'(exp_q.size()), 32'd0);

        out_ready = 1'b0;
        applyStimulus(0, 0, 0, 3, 32'h1234_5678, 0);
        applyStimulus(1, 0, 0, -9, 32'h8765_4321, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready1", 32'(in_ready), 32'd1);
        @(negedge clk);
        checkOutput("midreset_no_late", 32'(out_valid), 32'd0);

        applyStimulus(0, 0, 0, 1, 32'h0, 0);
        @(negedge clk);
        checkOutput("latency_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency_c2", 32'(out_valid), 32'd1);
        checkOutput("latency_val", out_posit, 32'h4800_0000);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
